adam_aes_encipher_iterative: RTL and testbench
==============================================

Name: adam_aes_encipher_iterative

Overview:
AES-128 encryption datapath that consumes the 11 round keys produced by the key-expansion stage and enciphers one 128-bit block at a time, one AES round per clock.
Sits directly downstream of the key expansion inside the AES peripheral core, between the key schedule and the peripheral's data/output registers.
Uses a valid/ready handshake on input and output, and a latched key-valid flag derived from the key schedule's one-cycle ready pulse.

Parameters:
NR, 10, number of AES rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
round_keys  input  128 x [0:10]  unpacked array of round keys from the key schedule; index 0 is the whitening key
keys_ready  input  1  one-cycle pulse from the key schedule when all round keys are valid
key_init  input  1  key schedule restart; invalidates the current keys
in_valid  input  1  block_in is valid
in_ready  output  1  block accepted when in_valid and in_ready are both high
block_in  input  128  plaintext, byte 0 in [127:120], FIPS-197 column-major
out_valid  output  1  block_out is valid
out_ready  input  1  consumer accepts block_out
block_out  output  128  ciphertext, same byte order as block_in
busy  output  1  high while a block is in rounds or awaiting output

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values: all outputs 0 (in_ready=0, out_valid=0, block_out=0, busy=0). Internally: keys_valid=0, fsm=IDLE, round_ctr=0, state=0.
- keys_valid:
  - set on the edge where keys_ready=1;
  - cleared on the edge where key_init=1;
  - key_init wins when both are high in the same cycle.
- in_ready = (fsm==IDLE) && keys_valid. This is combinational from registers only and has no dependency on in_valid.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - On an accept edge, state <= block_in ^ round_keys[0], round_ctr <= 1, and fsm goes to ROUND.
  - in_valid while keys_valid=0 is ignored; the block is held off, not dropped.
- ROUND, one round per edge:
  - t = ShiftRows(SubBytes(state)).
  - If round_ctr<10: state <= MixColumns(t) ^ round_keys[round_ctr], and round_ctr increments.
  - If round_ctr==10: state <= t ^ round_keys[10], and fsm goes to DONE.
- DONE:
  - out_valid=1 and block_out=state, both held stable until out_ready.
  - On the edge where out_valid and out_ready are both 1, fsm goes to IDLE and out_valid goes to 0.
  - in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency and throughput:
  - out_valid is high exactly 10 cycles after the accept edge.
  - Minimum period is 12 cycles per block when out_ready is held high.
- busy = (fsm != IDLE).
- SubBytes uses 16 combinational S-box byte lookups on the state, reused every round. xtime is {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
- round_keys must be stable from accept through round 10. Key stability is guaranteed only through keys_valid, which the schedule holds.
- key_init during ROUND or DONE:
  - the in-flight block is aborted: fsm goes to IDLE, out_valid goes to 0, and round_ctr goes to 0 on that edge;
  - no ciphertext is emitted;
  - state is not cleared.
- key_init in IDLE: only clears keys_valid.
- Asynchronous reset mid-operation returns to the reset values above immediately, with no partial output.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package adam_aes_pkg holds:
  - typedef aes_block_t = logic [127:0];
  - typedef enc_state_t = enum {IDLE, ROUND, DONE};
  - localparam AES128_NR = 10;
  - functions xtime, mixcolumn_word (32b), shiftrows (128b).
  - The same package is shared with the key expansion.
- One sub-module: adam_aes_subbytes_128. It wraps 16 instances of the existing adam_aes_sbox_byte and maps 128 bits in to 128 bits out, combinationally.

Test Plan:
- FIPS-197 App. B: round_keys from key 2b7e151628aed2a6abf7158809cf4f3c, pulse keys_ready, then block_in 3243f6a8885a308d313198a2e0370734 -> block_out 3925841d02dc09fbdc118597196a0b32, with out_valid high exactly 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, block_in 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Then send 3 back-to-back blocks with out_ready=1 -> one result every 12 cycles, all correct.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> block_out stable, in_ready=0, busy=1. Then release -> exactly one handshake, and in_ready rises on the next cycle.
- No keys: in_valid=1 after reset with no keys_ready pulse -> in_ready=0 and no accept. A later keys_ready pulse -> accept on the next edge and a correct result.
- Abort: assert key_init at round 5 -> fsm to IDLE, out_valid never rises, in_ready=0 until the next keys_ready. Also assert keys_ready and key_init in the same cycle -> keys_valid=0.
- Reset: pull reset_n low asynchronously mid-ROUND -> all outputs 0 immediately. After release, App. B encrypts correctly once keys_ready has been pulsed again.

Source files
------------

// File: rtl/adam_aes_pkg.sv
// Shared AES types and GF(2^8) column helpers for the key expansion and the encipher datapath.
// Byte 0 of a block sits in [127:120]; bytes run column-major (byte 4*c+r is row r, column c).
package adam_aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} enc_state_t;

    localparam int AES128_NR = 10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mixcolumn_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_block_t shiftrows(input aes_block_t s);
        aes_block_t r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
        return r;
    endfunction

endpackage

// File: rtl/adam_aes_sbox_byte.sv
// Single AES forward S-box lookup, purely combinational.
module adam_aes_sbox_byte (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Entry 0 occupies the top byte, so entry x starts at bit {~x, 3'b111}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TABLE[{~x, 3'b111} -: 8];

endmodule

// File: rtl/adam_aes_subbytes_128.sv
// SubBytes over a full 128-bit state: 16 parallel S-box lookups.
module adam_aes_subbytes_128
    import adam_aes_pkg::*;
(
    input  aes_block_t data,
    output aes_block_t result
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        adam_aes_sbox_byte u_sbox (
            .x(data[8*i +: 8]),
            .y(result[8*i +: 8])
        );
    end

endmodule

// File: rtl/adam_aes_encipher_iterative.sv
// Iterative AES-128 encipher: one round per clock using the key schedule's 11 round keys.
// Accepts one block when idle with valid keys; holds the ciphertext until the consumer takes it.
module adam_aes_encipher_iterative
    import adam_aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] round_keys [0:10],
    input  logic         keys_ready,
    input  logic         key_init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block_out,
    output logic         busy
);

    if (NR != AES128_NR) begin : g_nr_check
        $error("adam_aes_encipher_iterative supports only NR=10");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    enc_state_t fsm, fsm_next;
    logic [3:0] round_ctr, round_ctr_next;
    aes_block_t state, state_next;
    aes_block_t sub, shifted, mixed, round_key;
    logic       keys_valid;
    logic       accept;

    adam_aes_subbytes_128 u_subbytes (
        .data(state),
        .result(sub)
    );

    assign shifted = shiftrows(sub);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127-32*c -: 32] = mixcolumn_word(shifted[127-32*c -: 32]);
    end

    assign round_key = round_keys[round_ctr];
    assign in_ready  = (fsm == IDLE) && keys_valid;
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm == DONE);
    assign block_out = out_valid ? state : '0;
    assign busy      = (fsm != IDLE);

    always_comb begin
        fsm_next       = fsm;
        round_ctr_next = round_ctr;
        state_next     = state;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    state_next     = block_in ^ round_keys[0];
                    round_ctr_next = 4'd1;
                    fsm_next       = ROUND;
                end
            end
            ROUND: begin
                if (round_ctr == LAST_ROUND) begin
                    state_next = shifted ^ round_key;
                    fsm_next   = DONE;
                end else begin
                    state_next     = mixed ^ round_key;
                    round_ctr_next = round_ctr + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next       = IDLE;
                    round_ctr_next = '0;
                end
            end
            default: fsm_next = IDLE;
        endcase
        // A key restart kills the in-flight block; the partial state is simply left behind.
        if (key_init && fsm != IDLE) begin
            fsm_next       = IDLE;
            round_ctr_next = '0;
            state_next     = state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm        <= IDLE;
            round_ctr  <= '0;
            state      <= '0;
            keys_valid <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            round_ctr <= round_ctr_next;
            state     <= state_next;
            if (key_init)
                keys_valid <= 1'b0;
            else if (keys_ready)
                keys_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adam_aes_encipher_iterative.sv
// Bench for the iterative AES-128 encipher: FIPS-197 vectors plus random blocks against a byte-matrix model.
module tb_adam_aes_encipher_iterative;

    logic         clk = 1'b0;
    logic         reset_n, keys_ready, key_init, in_valid, in_ready;
    logic         out_valid, out_ready, busy;
    logic [127:0] block_in, block_out;
    logic [127:0] rk [0:10];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] sbox_t [256];

    typedef logic [10:0][127:0] rks_t;
    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs [6];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    adam_aes_encipher_iterative dut (
        .clk(clk), .reset_n(reset_n), .round_keys(rk), .keys_ready(keys_ready),
        .key_init(key_init), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .out_valid(out_valid), .out_ready(out_ready),
        .block_out(block_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: GF(2^8) arithmetic on a 4x4 byte matrix
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic rks_t expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rks_t        ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]] ^ rc, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        rks_t         ks;
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o, k;
        ks = expand_key(key);
        k = ks[0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            k = ks[rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd == 10) s[r][c] = t[r][c];
                    else s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                   ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
                end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_keys(input logic [127:0] key, input bit pulse);
        rks_t ks;
        ks = expand_key(key);
        for (int r = 0; r < 11; r++) rk[r] = ks[r];
        if (pulse) begin
            keys_ready = 1'b1;
            tick();
            keys_ready = 1'b0;
        end
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] exp,
                             input int stall);
        int n;
        block_in = pt;
        in_valid = 1'b1;
        wait_in_ready();
        chk({name, " in_ready"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        chk({name, " latency"}, 128'(n), 128'd10);
        repeat (stall) tick();
        chk({name, " block_out"}, block_out, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " out_valid after handshake"}, 128'(out_valid), 128'd0);
    endtask

    // ---------------- test
    initial begin
        int n;
        int acc [3];
        logic [127:0] pts [3];
        bit saw_valid, saw_ready;

        reset_n = 1'b0; keys_ready = 1'b0; key_init = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; block_in = '0;
        for (int r = 0; r < 11; r++) rk[r] = '0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_t[x] = b;
        end

        tick(); tick();
        chk("reset in_ready", 128'(in_ready), 128'd0);
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset block_out", block_out, 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        reset_n = 1'b1;
        tick();

        // No keys yet: block must be held off until a keys_ready pulse.
        set_keys(KEY_B, 1'b0);
        block_in = PT_B;
        in_valid = 1'b1;
        repeat (5) tick();
        chk("nokeys in_ready", 128'(in_ready), 128'd0);
        chk("nokeys busy", 128'(busy), 128'd0);
        keys_ready = 1'b1;
        tick();
        keys_ready = 1'b0;
        chk("keys pulse in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("accept busy", 128'(busy), 128'd1);
        wait_out_valid(n);
        chk("appB latency", 128'(n), 128'd10);
        chk("appB block_out", block_out, CT_B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Vector table: FIPS vectors plus random key/plaintext pairs.
        vecs[0] = '{"fips appB", KEY_B, PT_B, CT_B};
        vecs[1] = '{"fips appC1", KEY_C, PT_C, CT_C};
        for (int i = 2; i < 6; i++) begin
            vecs[i].name = $sformatf("rand%0d", i);
            vecs[i].key  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct   = aes_ref(vecs[i].key, vecs[i].pt);
        end
        for (int i = 0; i < 6; i++) begin
            set_keys(vecs[i].key, 1'b1);
            run_block(vecs[i].name, vecs[i].pt, vecs[i].ct, int'($urandom_range(0, 5)));
        end

        // Back-to-back with out_ready held high: one block per 12 cycles.
        set_keys(KEY_C, 1'b1);
        pts[0] = PT_C;
        pts[1] = {$urandom, $urandom, $urandom, $urandom};
        pts[2] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            block_in = pts[i];
            in_valid = 1'b1;
            wait_in_ready();
            tick();
            acc[i] = cyc;
            wait_out_valid(n);
            chk($sformatf("b2b%0d block_out", i), block_out,
                (i == 0) ? CT_C : aes_ref(KEY_C, pts[i]));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b period 0-1", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b period 1-2", 128'(acc[2] - acc[1]), 128'd12);

        // Backpressure: output held for 20 cycles, then exactly one handshake.
        set_keys(KEY_B, 1'b1);
        block_in = PT_B;
        in_valid = 1'b1;
        wait_in_ready();
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        for (int i = 0; i < 20; i++) begin
            chk("bp block_out", block_out, CT_B);
            chk("bp out_valid", 128'(out_valid), 128'd1);
            chk("bp in_ready", 128'(in_ready), 128'd0);
            chk("bp busy", 128'(busy), 128'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release out_valid", 128'(out_valid), 128'd0);
        chk("bp release in_ready", 128'(in_ready), 128'd1);
        chk("bp release busy", 128'(busy), 128'd0);
        tick();
        chk("bp single handshake", 128'(out_valid), 128'd0);

        // Abort mid-round via key_init.
        block_in = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        wait_in_ready();
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        key_init = 1'b1;
        tick();
        key_init = 1'b0;
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort out_valid", 128'(out_valid), 128'd0);
        chk("abort in_ready", 128'(in_ready), 128'd0);
        saw_valid = 1'b0;
        saw_ready = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
            if (in_ready) saw_ready = 1'b1;
        end
        chk("abort no output", 128'(saw_valid), 128'd0);
        chk("abort stays not ready", 128'(saw_ready), 128'd0);
        keys_ready = 1'b1;
        key_init = 1'b1;
        tick();
        keys_ready = 1'b0;
        key_init = 1'b0;
        chk("key_init beats keys_ready", 128'(in_ready), 128'd0);
        keys_ready = 1'b1;
        tick();
        keys_ready = 1'b0;
        chk("keys restored in_ready", 128'(in_ready), 128'd1);
        run_block("post-abort appB", PT_B, CT_B, 0);

        // Asynchronous reset mid-round.
        block_in = PT_B;
        in_valid = 1'b1;
        wait_in_ready();
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("pre-reset busy", 128'(busy), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset busy", 128'(busy), 128'd0);
        chk("async reset in_ready", 128'(in_ready), 128'd0);
        chk("async reset out_valid", 128'(out_valid), 128'd0);
        chk("async reset block_out", block_out, 128'd0);
        #2 reset_n = 1'b1;
        tick();
        chk("post-reset keys invalid", 128'(in_ready), 128'd0);
        set_keys(KEY_B, 1'b1);
        run_block("post-reset appB", PT_B, CT_B, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
